shift_frame_ctrl: RTL and testbench
===================================

# shift_frame_ctrl

Sequencer for the team's DFF shift-register chain. It accepts a parallel word over a valid/ready handshake and shifts it out serially, MSB- or LSB-first. It captures the serial input into a parallel word during the same shift cycles. It enforces a programmable inter-frame gap and reports each completed frame with a one-cycle pulse.

## Interface
Parameters:
- WIDTH, 8, bits per frame (≥2)
- GAP, 1, idle cycles inserted after each frame (≥0)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- load_data  in  WIDTH  parallel word to transmit
- load_valid  in  1  load_data valid
- load_ready  out  1  controller can accept a word this cycle
- msb_first  in  1  bit order; sampled only on the load handshake edge
- sin  in  1  serial input, sampled on each shift edge
- sout  out  1  serial output (registered shift-register end bit)
- shift_en  out  1  high while a frame is on sout
- done  out  1  one-cycle pulse after the last shift edge
- cap_data  out  WIDTH  word received on sin, valid while done=1, held until next done

## Operation
- States: IDLE, SHIFT, GAP.
- **IDLE:**
  - load_ready=1, shift_en=0, sout=0.
  - On an edge with load_valid & load_ready: shreg<=load_data, bit order latched, cnt<=0, go to SHIFT.
- **SHIFT:**
  - shift_en=1; sout = shreg[WIDTH-1] if msb_first, else shreg[0].
  - Each edge: shreg shifts toward the output end; sin enters the vacated end (LSB for msb_first, MSB otherwise); cnt increments.
  - On the edge with cnt==WIDTH-1:
    - cap_data<=the post-shift shreg, which includes that edge's sin.
    - done<=1.
    - Next state is GAP if GAP>0, else IDLE.
- **GAP:**
  - load_ready=0, shift_en=0, sout=0.
  - Stays GAP cycles, then goes to IDLE.
- **Back-to-back (GAP=0 only):**
  - load_ready is also 1 during the final SHIFT cycle (cnt==WIDTH-1).
  - A handshake on that edge loads the new word and stays in SHIFT with cnt<=0, giving zero idle cycles between frames.
  - done still pulses for the finished frame.
- **Handshake:**
  - A load is accepted only on an edge where load_valid & load_ready.
  - load_valid is ignored when load_ready=0; the word is not queued.
- **Bit order:**
  - msb_first changes mid-frame have no effect; the latched value applies for the whole frame.
  - cap_data: with msb_first=1, the first received bit lands in cap_data[WIDTH-1]; with msb_first=0, in cap_data[0].
- **Counter:** cnt is width $clog2(WIDTH); it never wraps past WIDTH-1.

## Timing
- Reset values: state=IDLE, sout=0, shift_en=0, done=0, cap_data=0, shreg=0, cnt=0.
- load_ready=0 while rst=1, and 1 from the first cycle after reset deasserts.
- Frame timeline for a handshake at edge E:
  - shift_en=1 and sout carries bit k during the cycle after edge E+k, for k=0..WIDTH-1.
  - sin is captured at edges E+1..E+WIDTH.
- done=1 for exactly one cycle after edge E+WIDTH.
- load_ready timing:
  - GAP>0: load_ready returns to 1 after edge E+WIDTH+GAP.
  - GAP=0: load_ready is 1 in the cycle after edge E+WIDTH-1.
- Rate: max throughput is one frame per WIDTH+GAP cycles.
- Reset mid-frame:
  - The next edge aborts the frame; no done pulse.
  - sout, shift_en and cap_data go to 0.
- rst and load_valid on the same edge: reset wins; the word is dropped.

## Test plan
- **Reset:** hold rst 2 cycles, then release.
  - Required: all outputs 0 during reset; load_ready=1 the cycle after release.
- **MSB-first frame** (WIDTH=8, GAP=1): load 8'hA5, msb_first=1, sin driven with the pattern 1,0,0,1,1,1,0,0.
  - Required on sout: 1,0,1,0,0,1,0,1 over 8 shift_en cycles.
  - Required on completion: done after the 8th bit; cap_data=8'h9C.
  - Required after the frame: load_ready low one GAP cycle.
- **LSB-first frame:** load 8'h01, msb_first=0, sin=1 constant.
  - Required: sout=1,0,0,0,0,0,0,0.
  - Required: cap_data=8'hFF.
- **Zero-gap streaming** (GAP=0): present 8'hF0 then 8'h0F with load_valid held high.
  - Required: 16 contiguous shift_en cycles; sout=11110000 00001111.
  - Required: two done pulses 8 cycles apart.
- **Reset mid-frame:** load 8'hFF, assert rst after the 3rd bit.
  - Required: shift_en and sout go to 0 on the next edge; no done.
  - Required: a new load after release transmits correctly.
- **Ignored load:** pulse load_valid during SHIFT and GAP (GAP=2).
  - Required: no state change, no extra frame.
  - Required: load_ready asserts exactly 2 cycles after done.

Source files
------------

// File: rtl/shift_frame_ctrl_if.sv
// ============================================================================
// Module   : shift_frame_ctrl_if
// Purpose  : Load handshake and serial/capture bundle for shift_frame_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface shift_frame_ctrl_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] load_data;
    logic             load_valid;
    logic             load_ready;
    logic             msb_first;
    logic             sin;
    logic             sout;
    logic             shift_en;
    logic             done;
    logic [WIDTH-1:0] cap_data;

    modport master (
        output load_data, load_valid, msb_first, sin,
        input  load_ready, sout, shift_en, done, cap_data
    );

    modport slave (
        input  load_data, load_valid, msb_first, sin,
        output load_ready, sout, shift_en, done, cap_data
    );
endinterface

`default_nettype wire

// File: rtl/shift_frame_ctrl.sv
// ============================================================================
// Module   : shift_frame_ctrl
// Purpose  : Serialises a loaded word MSB/LSB-first while capturing sin,
//            with a programmable inter-frame gap and a done pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_frame_ctrl #(
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    shift_frame_ctrl_if.slave bus
);
    localparam int c_cnt_w = $clog2(WIDTH);
    localparam int c_gap_w = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [c_cnt_w-1:0] c_last     = c_cnt_w'(WIDTH - 1);
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_shreg;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_gap_w-1:0] r_gap_cnt;
    logic               r_msb;
    logic               r_sout;
    logic               r_shift_en;
    logic               r_done;
    logic [WIDTH-1:0]   r_cap;

    logic               w_last;
    logic               w_ready;
    logic               w_load;
    logic [WIDTH-1:0]   w_shifted;
    logic               w_load_end;
    logic               w_shift_end;

    assign w_last  = (r_state == S_SHIFT) && (r_cnt == c_last);
    // With no gap the final shift cycle may accept the next word directly.
    assign w_ready = !rst && ((r_state == S_IDLE) || ((GAP == 0) && w_last));
    assign w_load  = bus.load_valid && w_ready;

    assign w_shifted   = r_msb ? {r_shreg[WIDTH-2:0], bus.sin}
                               : {bus.sin, r_shreg[WIDTH-1:1]};
    assign w_load_end  = bus.msb_first ? bus.load_data[WIDTH-1] : bus.load_data[0];
    assign w_shift_end = r_msb ? w_shifted[WIDTH-1] : w_shifted[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_shreg    <= '0;
            r_cnt      <= '0;
            r_gap_cnt  <= '0;
            r_msb      <= 1'b0;
            r_sout     <= 1'b0;
            r_shift_en <= 1'b0;
            r_done     <= 1'b0;
            r_cap      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_sout     <= 1'b0;
                    r_shift_en <= 1'b0;
                end
                S_SHIFT: begin
                    r_shreg <= w_shifted;
                    r_cnt   <= r_cnt + 1'b1;
                    r_sout  <= w_shift_end;
                    if (w_last) begin
                        r_cap      <= w_shifted;
                        r_done     <= 1'b1;
                        r_cnt      <= '0;
                        r_sout     <= 1'b0;
                        r_shift_en <= 1'b0;
                        r_gap_cnt  <= '0;
                        r_state    <= (GAP > 0) ? S_GAP : S_IDLE;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == c_gap_last) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // A load overrides the idle/end-of-frame updates above.
            if (w_load) begin
                r_shreg    <= bus.load_data;
                r_msb      <= bus.msb_first;
                r_cnt      <= '0;
                r_sout     <= w_load_end;
                r_shift_en <= 1'b1;
                r_state    <= S_SHIFT;
            end
        end
    end

    assign bus.load_ready = w_ready;
    assign bus.sout       = r_sout;
    assign bus.shift_en   = r_shift_en;
    assign bus.done       = r_done;
    assign bus.cap_data   = r_cap;

endmodule

`default_nettype wire

// File: tb/tb_shift_frame_ctrl.sv
// ============================================================================
// Module   : tb_shift_frame_ctrl
// Purpose  : Directed plus random frames on three instances (GAP = 1, 0, 2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_frame_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [W-1:0] ld [3];
    logic         lv [3];
    logic         mf [3];
    logic         si [3];
    logic         lr [3];
    logic         so [3];
    logic         se [3];
    logic         dn [3];
    logic [W-1:0] cd [3];

    int gap_of [3] = '{1, 0, 2};
    int n_checks = 0;
    int n_err    = 0;

    for (genvar i = 0; i < 3; i++) begin : g_dut
        shift_frame_ctrl_if #(.WIDTH(W)) bus ();
        shift_frame_ctrl #(
            .WIDTH(W),
            .GAP  ((i == 0) ? 1 : ((i == 1) ? 0 : 2))
        ) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );
        assign bus.load_data  = ld[i];
        assign bus.load_valid = lv[i];
        assign bus.msb_first  = mf[i];
        assign bus.sin        = si[i];
        assign lr[i] = bus.load_ready;
        assign so[i] = bus.sout;
        assign se[i] = bus.shift_en;
        assign dn[i] = bus.done;
        assign cd[i] = bus.cap_data;
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bit k on the wire for a word sent in the given order.
    function automatic logic exp_bit(input logic [W-1:0] word, input logic msb, input int k);
        return msb ? word[W-1-k] : word[k];
    endfunction

    // sins[k] is the k-th bit received in time.
    function automatic logic [W-1:0] exp_cap(input logic [W-1:0] sins, input logic msb);
        logic [W-1:0] c;
        c = '0;
        for (int k = 0; k < W; k++) begin
            if (msb) c[W-1-k] = sins[k];
            else     c[k]     = sins[k];
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int d);
        int t;
        t = 0;
        while (lr[d] !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        chk("ready_wait", lr[d], 1);
    endtask

    task automatic do_frame(input int d, input logic [W-1:0] word, input logic msb,
                            input logic [W-1:0] sins, input bit ign);
        logic [W-1:0] cap;
        wait_ready(d);
        ld[d] = word;
        mf[d] = msb;
        lv[d] = 1'b1;
        tick();
        lv[d] = 1'b0;
        mf[d] = 1'($urandom);
        ld[d] = W'($urandom);
        for (int k = 0; k < W; k++) begin
            si[d] = sins[k];
            chk("shift_en", se[d], 1);
            chk("sout", so[d], exp_bit(word, msb, k));
            chk("done_early", dn[d], 0);
            lv[d] = ign && (k % 2 == 1);
            tick();
            lv[d] = 1'b0;
        end
        cap = exp_cap(sins, msb);
        chk("done", dn[d], 1);
        chk("cap_data", cd[d], cap);
        chk("shift_en_end", se[d], 0);
        chk("sout_end", so[d], 0);
        for (int g = 0; g < gap_of[d]; g++) begin
            chk("gap_ready", lr[d], 0);
            lv[d] = ign;
            tick();
            lv[d] = 1'b0;
            chk("gap_done", dn[d], 0);
            chk("gap_shift_en", se[d], 0);
        end
        chk("ready_after", lr[d], 1);
        chk("cap_held", cd[d], cap);
    endtask

    initial begin
        logic [W-1:0] s0;
        logic [W-1:0] s1;
        logic [15:0]  stream;

        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            ld[d] = '0; lv[d] = 1'b0; mf[d] = 1'b0; si[d] = 1'b0;
        end
        repeat (2) begin
            tick();
            for (int d = 0; d < 3; d++) begin
                chk("rst_ready", lr[d], 0);
                chk("rst_sout", so[d], 0);
                chk("rst_shift_en", se[d], 0);
                chk("rst_done", dn[d], 0);
                chk("rst_cap", cd[d], 0);
            end
        end
        rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) chk("release_ready", lr[d], 1);
        tick();

        do_frame(0, 8'hA5, 1'b1, 8'b0011_1001, 1'b1);
        chk("msb_cap_9c", cd[0], 8'h9C);
        do_frame(0, 8'h01, 1'b0, 8'hFF, 1'b1);
        chk("lsb_cap_ff", cd[0], 8'hFF);
        do_frame(2, 8'h3C, 1'b1, 8'h5A, 1'b1);

        // Zero-gap streaming with load_valid held across both words.
        s0 = W'($urandom);
        s1 = W'($urandom);
        stream = 16'hF00F;
        wait_ready(1);
        ld[1] = 8'hF0; mf[1] = 1'b1; lv[1] = 1'b1;
        tick();
        ld[1] = 8'h0F;
        for (int k = 0; k < 16; k++) begin
            si[1] = (k < 8) ? s0[k] : s1[k-8];
            if (k == 8) lv[1] = 1'b0;
            chk("stream_shift_en", se[1], 1);
            chk("stream_sout", so[1], stream[15-k]);
            chk("stream_done", dn[1], (k == 8) ? 1 : 0);
            if (k == 8) chk("stream_cap0", cd[1], exp_cap(s0, 1'b1));
            tick();
        end
        chk("stream_done2", dn[1], 1);
        chk("stream_cap1", cd[1], exp_cap(s1, 1'b1));
        chk("stream_end", se[1], 0);

        // Reset during the third bit aborts the frame.
        wait_ready(0);
        ld[0] = 8'hFF; mf[0] = 1'b1; lv[0] = 1'b1;
        tick();
        lv[0] = 1'b0;
        tick();
        tick();
        chk("mid_shift_en", se[0], 1);
        rst = 1'b1;
        tick();
        chk("abort_shift_en", se[0], 0);
        chk("abort_sout", so[0], 0);
        chk("abort_cap", cd[0], 0);
        chk("abort_done", dn[0], 0);
        chk("abort_ready", lr[0], 0);
        rst = 1'b0;
        #1;
        chk("abort_release_ready", lr[0], 1);
        for (int k = 0; k < W; k++) begin
            tick();
            chk("abort_no_done", dn[0], 0);
            chk("abort_idle", se[0], 0);
        end
        do_frame(0, 8'hC3, 1'b0, W'($urandom), 1'b1);

        // Reset and load_valid on the same edge: the word is dropped.
        rst = 1'b1;
        ld[2] = 8'h81; lv[2] = 1'b1;
        tick();
        rst = 1'b0;
        lv[2] = 1'b0;
        #1;
        chk("rst_win_ready", lr[2], 1);
        tick();
        chk("rst_win_idle", se[2], 0);

        for (int it = 0; it < 9; it++) begin
            do_frame(it % 3, W'($urandom), 1'($urandom), W'($urandom), (it % 3) != 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule

`default_nettype wire
